// File: rtl/pp_cmd_driver_if.sv
// Bundle between the pp command driver, its host request/response streams and the pp operator core.
// The master modport is the driver's view; slave is the view of everything around it.
interface pp_cmd_driver_if #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [DATA_W-1:0] req_in1;
    logic [DATA_W-1:0] req_in2;

    logic              pp_reset;
    logic              pp_enable;
    logic [CMD_W-1:0]  pp_cmd;
    logic [DATA_W-1:0] pp_in1;
    logic [DATA_W-1:0] pp_in2;
    logic [DATA_W-1:0] pp_fpout;
    logic [DATA_W-1:0] pp_fxout;
    logic              pp_valid;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_fpout;
    logic [DATA_W-1:0] rsp_fxout;
    logic              rsp_timeout;

    logic [15:0]       done_count;
    logic [15:0]       timeout_count;

    modport master (
        input  req_valid, req_cmd, req_in1, req_in2,
        output req_ready,
        output pp_reset, pp_enable, pp_cmd, pp_in1, pp_in2,
        input  pp_fpout, pp_fxout, pp_valid,
        output rsp_valid, rsp_fpout, rsp_fxout, rsp_timeout,
        input  rsp_ready,
        output done_count, timeout_count
    );

    modport slave (
        output req_valid, req_cmd, req_in1, req_in2,
        input  req_ready,
        input  pp_reset, pp_enable, pp_cmd, pp_in1, pp_in2,
        output pp_fpout, pp_fxout, pp_valid,
        input  rsp_valid, rsp_fpout, rsp_fxout, rsp_timeout,
        output rsp_ready,
        input  done_count, timeout_count
    );
endinterface

// File: rtl/pp_cmd_driver.sv
// Issues one host request at a time to the pp operator core, returns its result, and resets the
// core at start-up and whenever it fails to answer within TIMEOUT wait cycles.
module pp_cmd_driver #(
    parameter int DATA_W     = 32,
    parameter int CMD_W      = 4,
    parameter int TIMEOUT    = 64,
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    pp_cmd_driver_if.master bus
);
    localparam int TIMER_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              pp_reset_q, pp_reset_d;
    logic              pp_enable_q, pp_enable_d;
    logic              req_ready_q, req_ready_d;
    logic [CMD_W-1:0]  pp_cmd_q, pp_cmd_d;
    logic [DATA_W-1:0] pp_in1_q, pp_in1_d;
    logic [DATA_W-1:0] pp_in2_q, pp_in2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_fpout_q, rsp_fpout_d;
    logic [DATA_W-1:0] rsp_fxout_q, rsp_fxout_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [15:0]       done_count_q, done_count_d;
    logic [15:0]       timeout_count_q, timeout_count_d;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        pp_reset_d      = pp_reset_q;
        pp_enable_d     = pp_enable_q;
        req_ready_d     = req_ready_q;
        pp_cmd_d        = pp_cmd_q;
        pp_in1_d        = pp_in1_q;
        pp_in2_d        = pp_in2_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_fpout_d     = rsp_fpout_q;
        rsp_fxout_d     = rsp_fxout_q;
        rsp_timeout_d   = rsp_timeout_q;
        done_count_d    = done_count_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            S_INIT: begin
                if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
                    state_d     = S_IDLE;
                    timer_d     = '0;
                    pp_reset_d  = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d     = S_ISSUE;
                    req_ready_d = 1'b0;
                    pp_enable_d = 1'b1;
                    pp_cmd_d    = bus.req_cmd;
                    pp_in1_d    = bus.req_in1;
                    pp_in2_d    = bus.req_in2;
                end
            end
            S_ISSUE: begin
                state_d     = S_WAIT;
                pp_enable_d = 1'b0;
                timer_d     = '0;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (bus.pp_valid) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_fpout_d   = bus.pp_fpout;
                    rsp_fxout_d   = bus.pp_fxout;
                    rsp_timeout_d = 1'b0;
                    timer_d       = '0;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    state_d    = S_RECOVER;
                    pp_reset_d = 1'b1;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_RECOVER: begin
                if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
                    state_d       = S_RESP;
                    timer_d       = '0;
                    pp_reset_d    = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_fpout_d   = '0;
                    rsp_fxout_d   = '0;
                    rsp_timeout_d = 1'b1;
                    if (timeout_count_q != 16'hFFFF) begin
                        timeout_count_d = timeout_count_q + 16'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    if (!rsp_timeout_q && done_count_q != 16'hFFFF) begin
                        done_count_d = done_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d     = S_INIT;
                timer_d     = '0;
                pp_reset_d  = 1'b1;
                pp_enable_d = 1'b0;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_INIT;
            timer_q         <= '0;
            pp_reset_q      <= 1'b1;
            pp_enable_q     <= 1'b0;
            req_ready_q     <= 1'b0;
            pp_cmd_q        <= '0;
            pp_in1_q        <= '0;
            pp_in2_q        <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_fpout_q     <= '0;
            rsp_fxout_q     <= '0;
            rsp_timeout_q   <= 1'b0;
            done_count_q    <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            pp_reset_q      <= pp_reset_d;
            pp_enable_q     <= pp_enable_d;
            req_ready_q     <= req_ready_d;
            pp_cmd_q        <= pp_cmd_d;
            pp_in1_q        <= pp_in1_d;
            pp_in2_q        <= pp_in2_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_fpout_q     <= rsp_fpout_d;
            rsp_fxout_q     <= rsp_fxout_d;
            rsp_timeout_q   <= rsp_timeout_d;
            done_count_q    <= done_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.pp_reset      = pp_reset_q;
    assign bus.pp_enable     = pp_enable_q;
    assign bus.pp_cmd        = pp_cmd_q;
    assign bus.pp_in1        = pp_in1_q;
    assign bus.pp_in2        = pp_in2_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_fpout     = rsp_fpout_q;
    assign bus.rsp_fxout     = rsp_fxout_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.done_count    = done_count_q;
    assign bus.timeout_count = timeout_count_q;
endmodule
